// File: rtl/enet_pkg.sv
// Shared definitions for the Ethernet PHY-interface mode-switch controller.
// Holds the controller state encoding, the standard interface mode codes and a
// one-hot decode helper used to drive the per-mode clock-gate enables.
package enet_pkg;

   // Controller states. LOCKED and ERR are the only states that take requests.
   typedef enum logic [2:0] {
      StDrain   = 3'd0,
      StWaitOff = 3'd1,
      StWaitOn  = 3'd2,
      StLocked  = 3'd3,
      StErr     = 3'd4
   } sw_state_e;

   // Mode codes as seen on {mii_select, rmii_select}.
   typedef enum logic [1:0] {
      ModeGmii  = 2'd0,
      ModeRgmii = 2'd1,
      ModeMii   = 2'd2,
      ModeRmii  = 2'd3
   } enet_mode_e;

   // Widest enable vector the decode helper supports; callers truncate.
   localparam int unsigned MaxModes = 32;

   function automatic logic [MaxModes-1:0] onehot_dec(input int unsigned code);
      logic [MaxModes-1:0] vec;
      vec = '0;
      if (code < MaxModes) begin
         vec[code[4:0]] = 1'b1;
      end
      return vec;
   endfunction

endpackage

// File: rtl/enet_mode_switch_ctrl_if.sv
// Mode-change request handshake between a CSR/requester and the controller.
//   mode_req       requested mode code
//   mode_req_valid request valid, held by the requester until accepted
//   mode_req_ready controller can take a request this cycle
interface enet_mode_switch_ctrl_if #(
   parameter int unsigned MODE_W = 2
) ();

   logic [MODE_W-1:0] mode_req;
   logic              mode_req_valid;
   logic              mode_req_ready;

   modport master (
      output mode_req,
      output mode_req_valid,
      input  mode_req_ready
   );

   modport slave (
      input  mode_req,
      input  mode_req_valid,
      output mode_req_ready
   );

endinterface

// File: rtl/enet_sw_timer.sv
// Per-state wait timer for the mode-switch controller.
//   clk, rst_n  system clock, asynchronous active-low reset
//   clear_i     restart the count from zero (state entry)
//   enable_i    count this cycle
//   expire_o    count has reached TIMEOUT_CYC-1, i.e. TIMEOUT_CYC cycles since clear
// The count saturates at the expiry value and never wraps.
module enet_sw_timer #(
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CntW-1:0] ExpCnt = CntW'(TIMEOUT_CYC - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != ExpCnt)) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == ExpCnt);

endmodule

// File: rtl/enet_mode_switch_ctrl.sv
// Ethernet PHY-interface mode-switch controller.
// Sequences a mode change: drain MAC traffic, hold the MAC, drop every per-mode
// clock enable, wait for the old clock to be confirmed off, enable the new one
// and wait for its lock. Brings up RST_MODE on its own after reset.
//   clk, rst_n              system clock, asynchronous active-low reset
//   req_if (slave)          mode_req / mode_req_valid / mode_req_ready handshake
//   tx_idle, rx_idle        MAC paths idle (clk-synchronous)
//   tx_ack, rx_ack          per-mode gate-enable-effective status (synchronised)
//   tx_clk_ena, rx_clk_ena  one-hot-or-zero gate enables
//   mac_hold                hold MAC during a switch
//   cur_mode                last successfully locked mode
//   txclk_lock, rxclk_lock  current mode locked (LOCKED state only)
//   switch_done             pulse: switch completed or same-mode request
//   drain_forced            pulse: drain gave up on idle and timed out
//   err_timeout             sticky: ack wait timed out
//   err_badmode             pulse: out-of-range mode request accepted
module enet_mode_switch_ctrl
   import enet_pkg::*;
#(
   parameter int unsigned NUM_MODES   = 4,
   parameter int unsigned MODE_W      = 2,
   parameter int unsigned RST_MODE    = 0,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   enet_mode_switch_ctrl_if.slave req_if,
   input  logic                  tx_idle,
   input  logic                  rx_idle,
   input  logic [NUM_MODES-1:0]  tx_ack,
   input  logic [NUM_MODES-1:0]  rx_ack,
   output logic [NUM_MODES-1:0]  tx_clk_ena,
   output logic [NUM_MODES-1:0]  rx_clk_ena,
   output logic                  mac_hold,
   output logic [MODE_W-1:0]     cur_mode,
   output logic                  txclk_lock,
   output logic                  rxclk_lock,
   output logic                  switch_done,
   output logic                  drain_forced,
   output logic                  err_timeout,
   output logic                  err_badmode
);

   localparam logic [MODE_W-1:0] RstMode = MODE_W'(RST_MODE);

   sw_state_e             state_q, state_d;
   logic [MODE_W-1:0]     tgt_q, tgt_d;
   logic [MODE_W-1:0]     cur_mode_q, cur_mode_d;
   logic [NUM_MODES-1:0]  ena_q, ena_d;
   logic                  mac_hold_q, mac_hold_d;
   logic                  switch_done_q, switch_done_d;
   logic                  drain_forced_q, drain_forced_d;
   logic                  err_timeout_q, err_timeout_d;
   logic                  err_badmode_q, err_badmode_d;

   logic                  ready;
   logic                  accept;
   logic                  req_bad;
   logic                  req_same;
   logic                  both_idle;
   logic                  acks_off;
   logic                  acks_on;
   logic                  in_locked;
   logic [NUM_MODES-1:0]  tgt_onehot;
   logic [NUM_MODES-1:0]  cur_onehot;
   logic                  tmr_clear;
   logic                  tmr_enable;
   logic                  tmr_expire;

   assign ready     = (state_q == StLocked) || (state_q == StErr);
   assign accept    = req_if.mode_req_valid & ready;
   assign req_bad   = (32'(req_if.mode_req) >= NUM_MODES);
   assign req_same  = (req_if.mode_req == cur_mode_q);
   assign both_idle = tx_idle & rx_idle;
   assign in_locked = (state_q == StLocked);

   assign tgt_onehot = NUM_MODES'(onehot_dec(32'(tgt_q)));
   assign cur_onehot = NUM_MODES'(onehot_dec(32'(cur_mode_q)));

   assign acks_off = ~(|tx_ack) & ~(|rx_ack);
   assign acks_on  = (|(tx_ack & tgt_onehot)) & (|(rx_ack & tgt_onehot));

   // Timer restarts on every state change and only runs in the wait states.
   assign tmr_clear  = (state_d != state_q);
   assign tmr_enable = (state_q == StDrain) || (state_q == StWaitOff) ||
                       (state_q == StWaitOn);

   enet_sw_timer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (tmr_clear),
      .enable_i(tmr_enable),
      .expire_o(tmr_expire)
   );

   always_comb begin
      state_d        = state_q;
      tgt_d          = tgt_q;
      cur_mode_d     = cur_mode_q;
      ena_d          = ena_q;
      mac_hold_d     = mac_hold_q;
      err_timeout_d  = err_timeout_q;
      switch_done_d  = 1'b0;
      drain_forced_d = 1'b0;
      err_badmode_d  = 1'b0;

      unique case (state_q)
         StLocked, StErr: begin
            if (accept) begin
               if (req_bad) begin
                  err_badmode_d = 1'b1;
               end else if (req_same && (state_q == StLocked)) begin
                  switch_done_d = 1'b1;
               end else begin
                  // From ERR even the old mode is a real switch.
                  tgt_d         = req_if.mode_req;
                  err_timeout_d = 1'b0;
                  state_d       = StDrain;
               end
            end
         end
         StDrain: begin
            if (both_idle || tmr_expire) begin
               state_d        = StWaitOff;
               ena_d          = '0;
               mac_hold_d     = 1'b1;
               drain_forced_d = ~both_idle;
            end
         end
         StWaitOff: begin
            // Enables only become non-zero here, after every ack is seen low,
            // so two enable bits can never be set together.
            if (acks_off) begin
               state_d = StWaitOn;
               ena_d   = tgt_onehot;
            end else if (tmr_expire) begin
               state_d       = StErr;
               ena_d         = '0;
               mac_hold_d    = 1'b1;
               err_timeout_d = 1'b1;
            end
         end
         StWaitOn: begin
            if (acks_on) begin
               state_d       = StLocked;
               mac_hold_d    = 1'b0;
               cur_mode_d    = tgt_q;
               switch_done_d = 1'b1;
            end else if (tmr_expire) begin
               state_d       = StErr;
               ena_d         = '0;
               mac_hold_d    = 1'b1;
               err_timeout_d = 1'b1;
            end
         end
         default: begin
            state_d       = StErr;
            ena_d         = '0;
            mac_hold_d    = 1'b1;
            err_timeout_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StWaitOff;
         tgt_q          <= RstMode;
         cur_mode_q     <= RstMode;
         ena_q          <= '0;
         mac_hold_q     <= 1'b1;
         switch_done_q  <= 1'b0;
         drain_forced_q <= 1'b0;
         err_timeout_q  <= 1'b0;
         err_badmode_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         tgt_q          <= tgt_d;
         cur_mode_q     <= cur_mode_d;
         ena_q          <= ena_d;
         mac_hold_q     <= mac_hold_d;
         switch_done_q  <= switch_done_d;
         drain_forced_q <= drain_forced_d;
         err_timeout_q  <= err_timeout_d;
         err_badmode_q  <= err_badmode_d;
      end
   end

   assign req_if.mode_req_ready = ready;
   assign tx_clk_ena   = ena_q;
   assign rx_clk_ena   = ena_q;
   assign mac_hold     = mac_hold_q;
   assign cur_mode     = cur_mode_q;
   assign txclk_lock   = in_locked & (|(tx_ack & cur_onehot));
   assign rxclk_lock   = in_locked & (|(rx_ack & cur_onehot));
   assign switch_done  = switch_done_q;
   assign drain_forced = drain_forced_q;
   assign err_timeout  = err_timeout_q;
   assign err_badmode  = err_badmode_q;

endmodule

// File: tb/tb_enet_mode_switch_ctrl.sv
// Scoreboard bench for enet_mode_switch_ctrl (3 modes, 16-cycle timeout).
// Stimulus pushes the expected output events (with the cycle they must appear
// in and a snapshot of the outputs); a negedge monitor pops and compares.
module tb_enet_mode_switch_ctrl;

   localparam int unsigned NumModes   = 3;
   localparam int unsigned ModeW      = 2;
   localparam int unsigned TimeoutCyc = 16;
   localparam int unsigned AckDly     = 3;

   localparam int EvDone   = 0;
   localparam int EvForced = 1;
   localparam int EvBad    = 2;
   localparam int EvErr    = 3;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                tx_idle, rx_idle;
   logic [NumModes-1:0] tx_ack, rx_ack, tx_clk_ena, rx_clk_ena;
   logic                mac_hold;
   logic [ModeW-1:0]    cur_mode;
   logic                txclk_lock, rxclk_lock;
   logic                switch_done, drain_forced, err_timeout, err_badmode;

   enet_mode_switch_ctrl_if #(.MODE_W(ModeW)) req_if ();

   enet_mode_switch_ctrl #(
      .NUM_MODES  (NumModes),
      .MODE_W     (ModeW),
      .RST_MODE   (0),
      .TIMEOUT_CYC(TimeoutCyc)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_if      (req_if),
      .tx_idle     (tx_idle),
      .rx_idle     (rx_idle),
      .tx_ack      (tx_ack),
      .rx_ack      (rx_ack),
      .tx_clk_ena  (tx_clk_ena),
      .rx_clk_ena  (rx_clk_ena),
      .mac_hold    (mac_hold),
      .cur_mode    (cur_mode),
      .txclk_lock  (txclk_lock),
      .rxclk_lock  (rxclk_lock),
      .switch_done (switch_done),
      .drain_forced(drain_forced),
      .err_timeout (err_timeout),
      .err_badmode (err_badmode)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Clock-gate model: ack follows enable AckDly cycles later, or instantly.
   logic [NumModes-1:0] tx_pipe [AckDly];
   logic [NumModes-1:0] rx_pipe [AckDly];
   logic                ack_instant;
   logic [NumModes-1:0] rx_mask;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < AckDly; i++) begin
            tx_pipe[i] <= '0;
            rx_pipe[i] <= '0;
         end
      end else begin
         tx_pipe[0] <= tx_clk_ena;
         rx_pipe[0] <= rx_clk_ena;
         for (int i = 1; i < AckDly; i++) begin
            tx_pipe[i] <= tx_pipe[i-1];
            rx_pipe[i] <= rx_pipe[i-1];
         end
      end
   end

   always_comb begin
      tx_ack = ack_instant ? tx_clk_ena : tx_pipe[AckDly-1];
      rx_ack = (ack_instant ? rx_clk_ena : rx_pipe[AckDly-1]) & ~rx_mask;
   end

   typedef struct {
      int                  kind;
      int unsigned         cyc;
      logic [ModeW-1:0]    mode;
      logic [NumModes-1:0] ena;
      logic                hold;
      logic                lock;
      logic                err;
   } ev_t;

   ev_t sb_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int unsigned c, input logic [ModeW-1:0] m,
                       input logic [NumModes-1:0] e, input logic h, input logic lk,
                       input logic er);
      ev_t ev;
      ev.kind = kind;
      ev.cyc  = c;
      ev.mode = m;
      ev.ena  = e;
      ev.hold = h;
      ev.lock = lk;
      ev.err  = er;
      sb_q.push_back(ev);
   endtask

   task automatic take(input int kind);
      ev_t ev;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
      end else begin
         ev = sb_q.pop_front();
         chk("ev_kind", 32'(kind), 32'(ev.kind));
         chk("ev_cycle", cyc, ev.cyc);
         chk("ev_cur_mode", 32'(cur_mode), 32'(ev.mode));
         chk("ev_tx_ena", 32'(tx_clk_ena), 32'(ev.ena));
         chk("ev_rx_ena", 32'(rx_clk_ena), 32'(ev.ena));
         chk("ev_mac_hold", 32'(mac_hold), 32'(ev.hold));
         chk("ev_txlock", 32'(txclk_lock), 32'(ev.lock));
         chk("ev_rxlock", 32'(rxclk_lock), 32'(ev.lock));
         chk("ev_err_timeout", 32'(err_timeout), 32'(ev.err));
      end
   endtask

   // Monitor: every DUT output event is matched against the scoreboard.
   logic err_prev = 1'b0;
   always @(negedge clk) begin
      chk("tx_ena_onehot0", 32'($countones(tx_clk_ena) <= 1), 32'd1);
      chk("rx_ena_onehot0", 32'($countones(rx_clk_ena) <= 1), 32'd1);
      if (rst_n) begin
         if (switch_done)               take(EvDone);
         if (drain_forced)              take(EvForced);
         if (err_badmode)               take(EvBad);
         if (err_timeout && !err_prev)  take(EvErr);
      end
      err_prev <= err_timeout;
   end

   task automatic req(input logic [ModeW-1:0] m, output int unsigned acc);
      int n;
      n = 0;
      @(negedge clk);
      req_if.mode_req       = m;
      req_if.mode_req_valid = 1'b1;
      while (!req_if.mode_req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_wait", 32'(req_if.mode_req_ready), 32'd1);
      acc = cyc + 1;
      @(posedge clk);
      #1;
      req_if.mode_req_valid = 1'b0;
   endtask

   task automatic wait_sb(input int limit);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < limit) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      int unsigned a;
      int unsigned base;
      tx_idle               = 1'b1;
      rx_idle               = 1'b1;
      ack_instant           = 1'b0;
      rx_mask               = '0;
      req_if.mode_req       = '0;
      req_if.mode_req_valid = 1'b0;
      rst_n                 = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_ready", 32'(req_if.mode_req_ready), 32'd0);
      chk("rst_tx_ena", 32'(tx_clk_ena), 32'd0);
      chk("rst_rx_ena", 32'(rx_clk_ena), 32'd0);
      chk("rst_mac_hold", 32'(mac_hold), 32'd1);
      chk("rst_cur_mode", 32'(cur_mode), 32'd0);
      chk("rst_locks", 32'({txclk_lock, rxclk_lock}), 32'd0);
      chk("rst_pulses", 32'({switch_done, drain_forced, err_badmode}), 32'd0);
      chk("rst_err_timeout", 32'(err_timeout), 32'd0);

      // Bring-up of GMII with 3-cycle acks: LOCKED at edge 5 after release.
      base  = cyc;
      rst_n = 1'b1;
      push(EvDone, base + 5, 2'd0, 3'b001, 1'b0, 1'b1, 1'b0);
      wait_sb(40);

      // GMII -> MII, delayed acks, idle: off seen at +5, on seen at +9.
      req(2'd2, a);
      push(EvDone, a + 9, 2'd2, 3'b100, 1'b0, 1'b1, 1'b0);
      wait_sb(40);

      // Drain timeout with tx_idle low, instant acks.
      ack_instant = 1'b1;
      tx_idle     = 1'b0;
      req(2'd1, a);
      push(EvForced, a + 16, 2'd2, 3'b000, 1'b1, 1'b0, 1'b0);
      push(EvDone, a + 18, 2'd1, 3'b010, 1'b0, 1'b1, 1'b0);
      wait_sb(60);
      tx_idle = 1'b1;

      // Minimum latency switch.
      req(2'd0, a);
      push(EvDone, a + 3, 2'd0, 3'b001, 1'b0, 1'b1, 1'b0);
      wait_sb(40);

      // rx ack of the target never rises: ERR 16 cycles after WAIT_ON entry.
      rx_mask = 3'b100;
      req(2'd2, a);
      push(EvErr, a + 18, 2'd0, 3'b000, 1'b1, 1'b0, 1'b1);
      wait_sb(60);
      chk("err_sticky", 32'(err_timeout), 32'd1);
      rx_mask = '0;
      // Old cur_mode from ERR is a real switch and clears err_timeout.
      req(2'd0, a);
      chk("err_cleared_on_accept", 32'(err_timeout), 32'd0);
      push(EvDone, a + 3, 2'd0, 3'b001, 1'b0, 1'b1, 1'b0);
      wait_sb(40);

      // Out-of-range mode, then same-mode no-op.
      req(2'd3, a);
      push(EvBad, a, 2'd0, 3'b001, 1'b0, 1'b1, 1'b0);
      wait_sb(20);
      chk("bad_ready_kept", 32'(req_if.mode_req_ready), 32'd1);
      req(2'd0, a);
      push(EvDone, a, 2'd0, 3'b001, 1'b0, 1'b1, 1'b0);
      wait_sb(20);

      // Reset mid-switch while in WAIT_ON.
      ack_instant = 1'b0;
      req(2'd1, a);
      while (cyc < a + 6) @(negedge clk);
      chk("pre_rst_ena", 32'(tx_clk_ena), 32'b010);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx_ena", 32'(tx_clk_ena), 32'd0);
      chk("mid_rst_rx_ena", 32'(rx_clk_ena), 32'd0);
      chk("mid_rst_mac_hold", 32'(mac_hold), 32'd1);
      chk("mid_rst_ready", 32'(req_if.mode_req_ready), 32'd0);
      chk("mid_rst_cur_mode", 32'(cur_mode), 32'd0);
      repeat (2) @(negedge clk);
      base  = cyc;
      rst_n = 1'b1;
      push(EvDone, base + 5, 2'd0, 3'b001, 1'b0, 1'b1, 1'b0);
      wait_sb(40);

      repeat (5) @(negedge clk);
      chk("sb_empty_end", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
